// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache miss arbiter.
package mem_arb_pkg;

    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int WORDS_PER_LINE = 8;
    localparam int MEM_LATENCY    = 4;
    localparam int LINE_BYTES     = 2 * WORDS_PER_LINE;
    localparam int WORD_IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFILL  = 2'd1,
        DFILL  = 2'd2,
        DWRITE = 2'd3
    } state_t;

    typedef logic owner_t;
    localparam owner_t OWNER_I = 1'b0;
    localparam owner_t OWNER_D = 1'b1;

    // Line-aligned base of a byte address.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and main-memory signals around the arbiter.
// slave  : arbiter view (takes requests and read data, drives memory and fill returns)
// master : environment view (caches and memory model)
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_stall;
    logic [DATA_W-1:0]     i_data;
    logic                  i_data_valid;
    logic [WORD_IDX_W-1:0] i_word;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_stall;
    logic [DATA_W-1:0]     d_data;
    logic                  d_data_valid;
    logic [WORD_IDX_W-1:0] d_word;

    logic                  mem_en;
    logic                  mem_wr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_rdata_valid;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdata_valid,
        output i_stall, i_data, i_data_valid, i_word,
        output d_stall, d_data, d_data_valid, d_word,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdata_valid,
        input  i_stall, i_data, i_data_valid, i_word,
        input  d_stall, d_data, d_data_valid, d_word,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_fill_ctr.sv
// Issue and receive counters for one cache line fill.
// The issue side walks 0..7 once per line; the receive side counts returned
// words and flags the last one. Both wrap 7->0 only at line end.
module mem_arb_fill_ctr
    import mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_clear,
    input  logic                  i_rvalid,
    output logic                  o_issue_active,
    output logic [WORD_IDX_W-1:0] o_issue_idx,
    output logic [WORD_IDX_W-1:0] o_word_idx,
    output logic                  o_last_word
);

    localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [WORD_IDX_W-1:0] ONE      = WORD_IDX_W'(1);

    logic                  r_busy;
    logic                  r_issue_done;
    logic [WORD_IDX_W-1:0] r_issue_cnt;
    logic [WORD_IDX_W-1:0] r_rx_cnt;

    // Counter update: start/clear zero everything, otherwise advance while a fill is live.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy       <= 1'b0;
            r_issue_done <= 1'b0;
            r_issue_cnt  <= '0;
            r_rx_cnt     <= '0;
        end else if (i_start || i_clear) begin
            r_busy       <= i_start;
            r_issue_done <= 1'b0;
            r_issue_cnt  <= '0;
            r_rx_cnt     <= '0;
        end else if (r_busy) begin
            if (!r_issue_done) begin
                r_issue_cnt <= r_issue_cnt + ONE;
                if (r_issue_cnt == LAST_IDX) begin
                    r_issue_done <= 1'b1;
                end
            end
            if (i_rvalid) begin
                r_rx_cnt <= r_rx_cnt + ONE;
                if (r_rx_cnt == LAST_IDX) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign o_issue_active = r_busy & ~r_issue_done;
    assign o_issue_idx    = r_issue_cnt;
    assign o_word_idx     = r_rx_cnt;
    assign o_last_word    = r_busy & i_rvalid & (r_rx_cnt == LAST_IDX);

endmodule

// File: rtl/mem_arbiter.sv
// I/D cache miss arbiter onto a single pipelined main-memory port.
// Build option: MEM_ARB_RR_EN selects round-robin between simultaneous
// I and D requests; undefined gives fixed D-over-I priority.
//
//   state  | meaning
//   IDLE   | no owner; grant decided at the end of this cycle
//   IFILL  | I-side line fill: issuing reads and/or receiving words
//   DFILL  | D-side line fill: issuing reads and/or receiving words
//   DWRITE | single-cycle D-side write-through on the memory port
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_W-1:0]     r_base;

    logic                  w_pick_d;
    logic                  w_in_fill;
    logic                  w_is_write;
    logic                  w_start;
    owner_t                w_owner;
    logic                  w_rvalid;
    logic                  w_fill_issue;
    logic                  w_i_valid;
    logic                  w_d_valid;
    logic                  w_i_done;
    logic                  w_d_done;

    logic                  w_issue_active;
    logic [WORD_IDX_W-1:0] w_issue_idx;
    logic [WORD_IDX_W-1:0] w_word_idx;
    logic                  w_last_word;

`ifdef MEM_ARB_RR_EN
    owner_t                r_prio;

    assign w_pick_d = bus.d_req & (~bus.i_req | (r_prio == OWNER_D));

    // Round-robin pointer: moves away from whichever side won a contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= OWNER_D;
        end else if (r_state == IDLE && bus.i_req && bus.d_req) begin
            r_prio <= w_pick_d ? OWNER_I : OWNER_D;
        end
    end
`else
    assign w_pick_d = bus.d_req;
`endif

    // Next-state: grant from IDLE, leave a fill on its last word, writes last one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_d) begin
                    w_state_next = bus.d_we ? DWRITE : DFILL;
                end else if (bus.i_req) begin
                    w_state_next = IFILL;
                end
            end
            IFILL, DFILL: begin
                if (w_last_word) begin
                    w_state_next = IDLE;
                end
            end
            DWRITE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_in_fill  = (r_state == IFILL) || (r_state == DFILL);
    assign w_is_write = (r_state == DWRITE);
    assign w_start    = (r_state == IDLE) &&
                        ((w_state_next == IFILL) || (w_state_next == DFILL));

    // State register and line base latched at fill grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_base  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_base <= line_base((w_state_next == IFILL) ? bus.i_addr : bus.d_addr);
            end
        end
    end

    // Read data only counts while a fill owns the port; anything else is dropped.
    assign w_rvalid = w_in_fill & bus.mem_rdata_valid;

    mem_arb_fill_ctr u_fill_ctr (
        .clk            (clk),
        .rst            (rst),
        .i_start        (w_start),
        .i_clear        (~w_in_fill),
        .i_rvalid       (w_rvalid),
        .o_issue_active (w_issue_active),
        .o_issue_idx    (w_issue_idx),
        .o_word_idx     (w_word_idx),
        .o_last_word    (w_last_word)
    );

    assign w_owner      = (r_state == IFILL) ? OWNER_I : OWNER_D;
    assign w_fill_issue = w_in_fill & w_issue_active;

    assign bus.mem_en    = w_fill_issue | w_is_write;
    assign bus.mem_wr    = w_is_write;
    assign bus.mem_addr  = w_is_write   ? bus.d_addr :
                           w_fill_issue ? r_base + ADDR_W'({w_issue_idx, 1'b0}) : '0;
    assign bus.mem_wdata = w_is_write ? bus.d_wdata : '0;

    assign w_i_valid = w_rvalid & (w_owner == OWNER_I);
    assign w_d_valid = w_rvalid & (w_owner == OWNER_D);

    assign bus.i_data_valid = w_i_valid;
    assign bus.i_data       = w_i_valid ? bus.mem_rdata : '0;
    assign bus.i_word       = w_i_valid ? w_word_idx : '0;
    assign bus.d_data_valid = w_d_valid;
    assign bus.d_data       = w_d_valid ? bus.mem_rdata : '0;
    assign bus.d_word       = w_d_valid ? w_word_idx : '0;

    // Stall drops in the owner's final cycle so the requester can retire next cycle.
    assign w_i_done    = w_i_valid & w_last_word;
    assign w_d_done    = (w_d_valid & w_last_word) | w_is_write;
    assign bus.i_stall = bus.i_req & ~w_i_done;
    assign bus.d_stall = bus.d_req & ~w_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a pipelined main-memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        i_stall;
        logic        i_dv;
        logic [2:0]  i_word;
        logic [15:0] i_data;
        logic        d_stall;
        logic        d_dv;
        logic [2:0]  d_word;
        logic [15:0] d_data;
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } out_t;

    typedef struct packed {
        logic        en;
        logic [15:0] addr;
        logic        valid;
        logic [2:0]  word;
        logic [15:0] data;
        logic        done;
    } fill_t;

    // Memory contents: fixed pattern derived from the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Expected fill activity r cycles after the grant edge (r = 1 is the first fill cycle).
    function automatic fill_t fill_at(input int r, input logic [15:0] base);
        fill_t f;
        f = '0;
        if (r >= 1 && r <= 8) begin
            f.en   = 1'b1;
            f.addr = base + 16'(2 * (r - 1));
        end
        if (r >= 5 && r <= 12) begin
            f.valid = 1'b1;
            f.word  = 3'(r - 5);
            f.data  = mem_word(base + 16'(2 * (r - 5)));
        end
        f.done = (r == 12);
        return f;
    endfunction

    function automatic out_t obs();
        out_t o;
        o.i_stall = bus.i_stall;
        o.i_dv    = bus.i_data_valid;
        o.i_word  = bus.i_word;
        o.i_data  = bus.i_data;
        o.d_stall = bus.d_stall;
        o.d_dv    = bus.d_data_valid;
        o.d_word  = bus.d_word;
        o.d_data  = bus.d_data;
        o.en      = bus.mem_en;
        o.wr      = bus.mem_wr;
        o.addr    = bus.mem_addr;
        o.wdata   = bus.mem_wdata;
        return o;
    endfunction

    // Pipelined read memory, MEM_LATENCY cycles from issue to data; cleared by rst.
    logic [15:0] pipe_a [MEM_LATENCY];
    logic        pipe_v [MEM_LATENCY];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
            end
        end else begin
            pipe_v[0] <= bus.mem_en & ~bus.mem_wr;
            pipe_a[0] <= bus.mem_addr;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
        end
    end

    assign bus.mem_rdata_valid = pipe_v[MEM_LATENCY-1];
    assign bus.mem_rdata       = pipe_v[MEM_LATENCY-1] ? mem_word(pipe_a[MEM_LATENCY-1]) : '0;

    task automatic test_reset;
        out_t got;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = obs();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 0", got);
        end
        for (int c = 0; c <= 2; c++) begin
            @(posedge clk); #1;
            if (c == 0) rst = 1'b0;
            @(negedge clk);
            got = obs();
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_idle c%0d: got %h expected 0", c, got);
            end
        end
    endtask

    task automatic test_ifill;
        out_t got, e;
        fill_t f;
        for (int c = 0; c <= 13; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                bus.i_req  = 1'b1;
                bus.i_addr = 16'h1236;
            end
            if (c == 13) bus.i_req = 1'b0;
            @(negedge clk);
            f = fill_at(c, 16'h1230);
            e = '0;
            e.i_stall = (c <= 11);
            e.i_dv    = f.valid;
            e.i_word  = f.word;
            e.i_data  = f.data;
            e.en      = f.en;
            e.addr    = f.addr;
            got = obs();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL ifill c%0d: got %h expected %h", c, got, e);
            end
        end
    endtask

    task automatic test_dwrite;
        out_t got, e;
        for (int c = 0; c <= 2; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'b1;
                bus.d_addr  = 16'h4000;
                bus.d_wdata = 16'hBEEF;
            end
            if (c == 2) begin
                bus.d_req   = 1'b0;
                bus.d_we    = 1'b0;
                bus.d_wdata = '0;
            end
            @(negedge clk);
            e = '0;
            e.d_stall = (c == 0);
            if (c == 1) begin
                e.en    = 1'b1;
                e.wr    = 1'b1;
                e.addr  = 16'h4000;
                e.wdata = 16'hBEEF;
            end
            got = obs();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL dwrite c%0d: got %h expected %h", c, got, e);
            end
        end
    endtask

    // Simultaneous I and D read misses; i_first selects which side is expected to win.
    task automatic test_priority(input bit i_first);
        out_t got, e;
        fill_t fi, fd;
        for (int c = 0; c <= 26; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                bus.i_req  = 1'b1;
                bus.i_addr = 16'h2008;
                bus.d_req  = 1'b1;
                bus.d_we   = 1'b0;
                bus.d_addr = 16'h300A;
            end
            if (c == 13) begin
                if (i_first) bus.i_req = 1'b0;
                else         bus.d_req = 1'b0;
            end
            if (c == 26) begin
                if (i_first) bus.d_req = 1'b0;
                else         bus.i_req = 1'b0;
            end
            @(negedge clk);
            fi = i_first ? fill_at(c, 16'h2000) : fill_at(c - 13, 16'h2000);
            fd = i_first ? fill_at(c - 13, 16'h3000) : fill_at(c, 16'h3000);
            e = '0;
            e.i_stall = i_first ? (c <= 11) : (c <= 24);
            e.d_stall = i_first ? (c <= 24) : (c <= 11);
            e.i_dv    = fi.valid;
            e.i_word  = fi.word;
            e.i_data  = fi.data;
            e.d_dv    = fd.valid;
            e.d_word  = fd.word;
            e.d_data  = fd.data;
            e.en      = fi.en | fd.en;
            e.addr    = fi.addr | fd.addr;
            got = obs();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL priority(i_first=%0d) c%0d: got %h expected %h", i_first, c, got, e);
            end
        end
    endtask

    // Write-through raised mid I-fill waits until the port returns to IDLE.
    task automatic test_write_wait;
        out_t got, e;
        fill_t f;
        for (int c = 0; c <= 15; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                bus.i_req  = 1'b1;
                bus.i_addr = 16'h5A5E;
            end
            if (c == 6) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'b1;
                bus.d_addr  = 16'h4010;
                bus.d_wdata = 16'h1234;
            end
            if (c == 13) bus.i_req = 1'b0;
            if (c == 15) begin
                bus.d_req   = 1'b0;
                bus.d_we    = 1'b0;
                bus.d_wdata = '0;
            end
            @(negedge clk);
            f = fill_at(c, 16'h5A50);
            e = '0;
            e.i_stall = (c <= 11);
            e.i_dv    = f.valid;
            e.i_word  = f.word;
            e.i_data  = f.data;
            e.d_stall = (c >= 6) && (c <= 13);
            e.en      = f.en;
            e.addr    = f.addr;
            if (c == 14) begin
                e.en    = 1'b1;
                e.wr    = 1'b1;
                e.addr  = 16'h4010;
                e.wdata = 16'h1234;
            end
            got = obs();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL write_wait c%0d: got %h expected %h", c, got, e);
            end
        end
    endtask

    // Reset during a D fill, then a clean fill afterwards.
    task automatic test_reset_mid_fill;
        out_t got, e;
        fill_t f;
        for (int c = 0; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                bus.d_req  = 1'b1;
                bus.d_we   = 1'b0;
                bus.d_addr = 16'h600C;
            end
            if (c == 7) rst = 1'b1;
            if (c == 8) begin
                rst       = 1'b0;
                bus.d_req = 1'b0;
            end
            if (c == 17) begin
                bus.d_req  = 1'b1;
                bus.d_addr = 16'h6002;
            end
            if (c == 30) bus.d_req = 1'b0;
            @(negedge clk);
            e = '0;
            f = '0;
            if (c <= 7) begin
                f = fill_at(c, 16'h6000);
                e.d_stall = 1'b1;
            end else if (c >= 17) begin
                f = fill_at(c - 17, 16'h6000);
                e.d_stall = (c <= 28);
            end
            e.d_dv   = f.valid;
            e.d_word = f.word;
            e.d_data = f.data;
            e.en     = f.en;
            e.addr   = f.addr;
            got = obs();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid_fill c%0d: got %h expected %h", c, got, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        test_reset();
        test_ifill();
        test_dwrite();
        test_priority(1'b0);
`ifdef MEM_ARB_RR_EN
        test_priority(1'b1);
`else
        test_priority(1'b0);
`endif
        test_write_wait();
        test_reset_mid_fill();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
